// File: rtl/seg_traffic_monitor.sv
// Traffic-light monitor: debounces a 4-digit 7-segment frame, decodes both light codes and flags protocol faults.
// Optional macro SEG_MON_DWELL_EN builds the saturating dwell counter; otherwise dwell is tied to 0.
module seg_traffic_monitor #(
  parameter int STABLE_CYC = 2,
  parameter int DWELL_W    = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [27:0]        seg_in,
  input  logic               clr_fault,
  output logic [1:0]         La,
  output logic [1:0]         Lb,
  output logic               valid,
  output logic               change,
  output logic               fault,
  output logic [2:0]         fault_code,
  output logic [DWELL_W-1:0] dwell
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  localparam logic [6:0] DIG_ZERO = 7'h40;
  localparam logic [6:0] DIG_ONE  = 7'h79;
  localparam logic [1:0] GREEN    = 2'b00;
  localparam logic [1:0] YELLOW   = 2'b01;
  localparam logic [1:0] RED      = 2'b10;
  localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYC - 1);

  state_t      state, next_state;
  logic [27:0] seg_q;
  logic [3:0]  stab_cnt;
  logic        accept;
  logic [3:0]  code_bits;
  logic [1:0]  new_la, new_lb;
  logic        bad_digit, code_11, seq_err, frame_err, frame_diff;
  logic [2:0]  err_code;

  function automatic logic legal_step(input logic [1:0] cur, input logic [1:0] nxt);
    legal_step = (nxt == cur) ||
                 (cur == GREEN  && nxt == YELLOW) ||
                 (cur == YELLOW && nxt == RED) ||
                 (cur == RED    && nxt == GREEN);
  endfunction

  // A frame is accepted once it has matched its registered copy for STABLE_CYC edges.
  assign accept = (seg_in == seg_q) && (stab_cnt == CNT_MAX);

  always_comb begin
    bad_digit = 1'b0;
    code_bits = '0;
    for (int i = 0; i < 4; i++) begin
      if (seg_in[i*7 +: 7] == DIG_ONE)
        code_bits[i] = 1'b1;
      else if (seg_in[i*7 +: 7] != DIG_ZERO)
        bad_digit = 1'b1;
    end
    new_la     = code_bits[3:2];
    new_lb     = code_bits[1:0];
    code_11    = (new_la == 2'b11) || (new_lb == 2'b11);
    // Sequence legality only means something once a previous frame is being tracked.
    seq_err    = ((state == TRACK) && (!legal_step(La, new_la) || !legal_step(Lb, new_lb))) ||
                 ((new_la != RED) && (new_lb != RED));
    frame_err  = bad_digit || code_11 || seq_err;
    frame_diff = (new_la != La) || (new_lb != Lb);
    if (bad_digit)
      err_code = 3'b001;
    else if (code_11)
      err_code = 3'b010;
    else
      err_code = 3'b100;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = frame_err ? FAULT : TRACK;
      TRACK:   if (accept && frame_err) next_state = FAULT;
      FAULT:   if (clr_fault) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == TRACK);
    fault = (state == FAULT);
  end

  // Leaving FAULT restarts debouncing so a still-present frame must settle again.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      seg_q    <= '0;
      stab_cnt <= '0;
    end else begin
      seg_q <= seg_in;
      if (state == FAULT && clr_fault)
        stab_cnt <= '0;
      else if (seg_in != seg_q)
        stab_cnt <= '0;
      else if (stab_cnt != CNT_MAX)
        stab_cnt <= stab_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      La         <= RED;
      Lb         <= RED;
      change     <= 1'b0;
      fault_code <= 3'b000;
    end else begin
      change <= 1'b0;
      if (accept && state != FAULT) begin
        if (frame_err) begin
          fault_code <= err_code;
        end else if (state == IDLE) begin
          La <= new_la;
          Lb <= new_lb;
        end else if (frame_diff) begin
          La     <= new_la;
          Lb     <= new_lb;
          change <= 1'b1;
        end
      end
    end
  end

`ifdef SEG_MON_DWELL_EN
  logic [DWELL_W-1:0] dwell_q;

  // Counts in TRACK only; a faulting frame freezes it at the value it had.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      dwell_q <= '0;
    else if (state == TRACK) begin
      if (accept && !frame_err && frame_diff)
        dwell_q <= '0;
      else if (!(accept && frame_err) && (dwell_q != '1))
        dwell_q <= dwell_q + 1'b1;
    end
  end

  assign dwell = dwell_q;
`else
  assign dwell = '0;
`endif

endmodule

// File: tb/tb_seg_traffic_monitor.sv
// Directed self-checking bench for seg_traffic_monitor (default STABLE_CYC=2).
module tb_seg_traffic_monitor;

  localparam logic [6:0]  D0     = 7'h40;
  localparam logic [6:0]  D1     = 7'h79;
  localparam logic [27:0] F_R_G  = {D1, D0, D0, D0};
  localparam logic [27:0] F_R_Y  = {D1, D0, D0, D1};
  localparam logic [27:0] F_R_R  = {D1, D0, D1, D0};
  localparam logic [27:0] F_BAD  = {D1, D0, D0, 7'h7F};
  localparam logic [27:0] F_G_G  = {D0, D0, D0, D0};
  localparam logic [27:0] F_R_11 = {D1, D0, D1, D1};
`ifdef SEG_MON_DWELL_EN
  localparam logic [15:0] DWELL_AFTER_ONE = 16'd1;
`else
  localparam logic [15:0] DWELL_AFTER_ONE = 16'd0;
`endif

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [27:0] seg_in;
  logic        clr_fault;
  logic [1:0]  La, Lb;
  logic        valid, change, fault;
  logic [2:0]  fault_code;
  logic [15:0] dwell;

  int checks = 0;
  int errors = 0;

  seg_traffic_monitor #(.STABLE_CYC(2), .DWELL_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .seg_in(seg_in), .clr_fault(clr_fault),
    .La(La), .Lb(Lb), .valid(valid), .change(change), .fault(fault),
    .fault_code(fault_code), .dwell(dwell)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_La"}, 32'(La), 32'h2);
    check_output({tag, "_Lb"}, 32'(Lb), 32'h2);
    check_output({tag, "_valid"}, 32'(valid), 32'h0);
    check_output({tag, "_change"}, 32'(change), 32'h0);
    check_output({tag, "_fault"}, 32'(fault), 32'h0);
    check_output({tag, "_code"}, 32'(fault_code), 32'h0);
    check_output({tag, "_dwell"}, 32'(dwell), 32'h0);
  endtask

  initial begin
    seg_in    = F_R_G;
    clr_fault = 1'b0;
    #1 Reset = 1'b0;
    #2;
    check_reset_values("reset");
    tick(2);
    Reset = 1'b1;

    // First frame: red/green accepted from IDLE without a change strobe.
    tick(2);
    check_output("idle_not_yet", 32'(valid), 32'h0);
    tick(1);
    check_output("first_valid", 32'(valid), 32'h1);
    check_output("first_La", 32'(La), 32'h2);
    check_output("first_Lb", 32'(Lb), 32'h0);
    check_output("first_change", 32'(change), 32'h0);

    // B moves green -> yellow.
    seg_in = F_R_Y;
    tick(2);
    check_output("pre_chg_change", 32'(change), 32'h0);
    check_output("pre_chg_Lb", 32'(Lb), 32'h0);
    tick(1);
    check_output("chg_change", 32'(change), 32'h1);
    check_output("chg_Lb", 32'(Lb), 32'h1);
    check_output("chg_dwell", 32'(dwell), 32'h0);
    tick(1);
    check_output("chg_one_cycle", 32'(change), 32'h0);
    check_output("dwell_after_one", 32'(dwell), 32'(DWELL_AFTER_ONE));

    // One-cycle glitch to a legal different frame must be ignored.
    seg_in = F_R_R;
    tick(1);
    seg_in = F_R_Y;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_output("glitch_change", 32'(change), 32'h0);
      check_output("glitch_Lb", 32'(Lb), 32'h1);
    end

    // Frame toggling every cycle is never accepted.
    for (int i = 0; i < 8; i++) begin
      seg_in = (i % 2 == 1) ? F_R_Y : F_R_R;
      tick(1);
      check_output("toggle_change", 32'(change), 32'h0);
      check_output("toggle_Lb", 32'(Lb), 32'h1);
    end
    tick(3);

    // Bad digit: fault 001, lights retained, sticky until clr_fault.
    seg_in = F_BAD;
    tick(2);
    check_output("bad_pre_fault", 32'(fault), 32'h0);
    tick(1);
    check_output("bad_fault", 32'(fault), 32'h1);
    check_output("bad_code", 32'(fault_code), 32'h1);
    check_output("bad_valid", 32'(valid), 32'h0);
    check_output("bad_La", 32'(La), 32'h2);
    check_output("bad_Lb", 32'(Lb), 32'h1);
    check_output("bad_change", 32'(change), 32'h0);
    tick(3);
    check_output("bad_sticky", 32'(fault), 32'h1);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    seg_in = F_R_Y;
    check_output("clr_fault", 32'(fault), 32'h0);
    check_output("clr_valid", 32'(valid), 32'h0);
    tick(3);
    check_output("retrack_valid", 32'(valid), 32'h1);
    check_output("retrack_change", 32'(change), 32'h0);
    check_output("retrack_Lb", 32'(Lb), 32'h1);

    // Both green: illegal step on B plus conflict -> code 100.
    seg_in = F_G_G;
    tick(3);
    check_output("conf_fault", 32'(fault), 32'h1);
    check_output("conf_code", 32'(fault_code), 32'h4);
    check_output("conf_La", 32'(La), 32'h2);
    check_output("conf_Lb", 32'(Lb), 32'h1);
    check_output("conf_change", 32'(change), 32'h0);
`ifndef SEG_MON_DWELL_EN
    check_output("conf_dwell", 32'(dwell), 32'h0);
`endif
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;

    // Code 11 as the first frame out of IDLE -> FAULT with code 010.
    seg_in = F_R_11;
    tick(3);
    check_output("c11_fault", 32'(fault), 32'h1);
    check_output("c11_code", 32'(fault_code), 32'h2);
    check_output("c11_Lb", 32'(Lb), 32'h1);

    // Asynchronous reset during FAULT.
    #2 Reset = 1'b0;
    #1;
    check_reset_values("async_fault");
    seg_in = F_R_G;
    tick(1);
    Reset = 1'b1;

    // Reset again mid-count: the pending frame is discarded.
    tick(2);
    #2 Reset = 1'b0;
    #1;
    check_output("midcnt_valid", 32'(valid), 32'h0);
    tick(1);
    Reset = 1'b1;
    tick(2);
    check_output("midcnt_discard", 32'(valid), 32'h0);
    tick(1);
    check_output("midcnt_accept", 32'(valid), 32'h1);
    check_output("midcnt_La", 32'(La), 32'h2);
    check_output("midcnt_Lb", 32'(Lb), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
